// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC3 microsequencer: the state encoding, opcode
// values, ALU operation codes, datapath mux select codes and the HALT trap
// vector. Imported by the controller and its memory timer.
package lc3_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC,
        S_ALU, S_BR, S_JMP, S_LEA, S_ADDR,
        S_RD, S_WB, S_SD, S_WR, S_HALT, S_ILL
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_AND   = 2'b00;
    localparam logic [1:0] ALU_NOT   = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

    localparam logic       A1M_SR1    = 1'b0;
    localparam logic       A1M_PC     = 1'b1;
    localparam logic [1:0] A2M_SEXT11 = 2'd0;
    localparam logic [1:0] A2M_SEXT9  = 2'd1;
    localparam logic [1:0] A2M_SEXT6  = 2'd2;
    localparam logic [1:0] A2M_ZERO   = 2'd3;
    localparam logic [1:0] PCMUX_BUS  = 2'd0;
    localparam logic [1:0] PCMUX_ADDR = 2'd1;
    localparam logic [1:0] PCMUX_INC  = 2'd2;
    localparam logic       MARMUX_ZEXT8 = 1'b0;
    localparam logic       MARMUX_ADDR  = 1'b1;

    localparam logic [7:0] TRAP_HALT = 8'h25;

    // LD and LDR go through the read path; ST and STR through the store path.
    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR);
    endfunction

endpackage

// File: rtl/lc3_control_if.sv
// Control/status bundle between the LC3 controller and its datapath.
//   ir, cc             : datapath -> controller (instruction register, nzp)
//   ld_*, gate_*, sels : controller -> datapath (loads, bus drivers, muxes)
//   mem_en, mem_rw     : controller -> memory (MDR source, write strobe)
// master = controller side, slave = datapath side.
interface lc3_control_if;
    logic [15:0] ir;
    logic [2:0]  cc;
    logic        ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr;
    logic [2:0]  dr, sr1, sr2;
    logic [1:0]  aluk;
    logic        gate_alu, gate_pc, gate_marmux, gate_mdr;
    logic        a1m_sel;
    logic [1:0]  a2m_sel, pcmux_sel;
    logic        marmux_sel, mem_en, mem_rw;

    modport master (
        input  ir, cc,
        output ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr,
        output dr, sr1, sr2, aluk,
        output gate_alu, gate_pc, gate_marmux, gate_mdr,
        output a1m_sel, a2m_sel, pcmux_sel, marmux_sel, mem_en, mem_rw
    );

    modport slave (
        output ir, cc,
        input  ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr,
        input  dr, sr1, sr2, aluk,
        input  gate_alu, gate_pc, gate_marmux, gate_mdr,
        input  a1m_sel, a2m_sel, pcmux_sel, marmux_sel, mem_en, mem_rw
    );
endinterface

// File: rtl/lc3_mem_timer.sv
// Fixed-latency memory access timer shared by the fetch, read and write
// states. Counts 0..MEM_CYCLES-1 while en is high and flags the final count.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : an access is in progress this cycle
//   done       : this is the last cycle of the access
module lc3_mem_timer #(
    parameter int MEM_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);
    localparam logic [3:0] LAST = 4'(MEM_CYCLES - 1);

    logic [3:0] count;

    assign done = en && (count == LAST);

    // Wrapping on done (or idling) guarantees the count is 0 for the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (!en || done)
            count <= '0;
        else
            count <= count + 4'd1;
    end
endmodule

// File: rtl/lc3_control.sv
// LC3 microsequencer: a Moore FSM that drives every control input of the
// datapath for ADD/AND/NOT/BR/JMP/LD/LDR/ST/STR/LEA and TRAP x25 (HALT).
//   clk, rst_n      : clock, asynchronous active-low reset
//   run             : start/continue, sampled in IDLE and at instruction end
//   bus (master)    : ir/cc in, loads/gates/selects/memory strobes out
//   halted, illegal : sticky status; illegal implies halted
module lc3_control
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    lc3_control_if.master bus,
    output logic          halted,
    output logic          illegal
);
    state_t     state, state_next, end_state;
    logic [3:0] opcode;
    logic       br_taken, timer_en, timer_done;

    assign opcode    = bus.ir[15:12];
    assign br_taken  = |(bus.ir[11:9] & bus.cc);
    assign end_state = run ? S_F1 : S_IDLE;

    // HALT and ILL are terminal, so decoding the state gives sticky flags.
    assign halted  = (state == S_HALT) || (state == S_ILL);
    assign illegal = (state == S_ILL);

    lc3_mem_timer #(.MEM_CYCLES(MEM_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next      = state;
        timer_en        = 1'b0;
        bus.ld_ir       = 1'b0;
        bus.ld_reg      = 1'b0;
        bus.ld_pc       = 1'b0;
        bus.ld_cc       = 1'b0;
        bus.ld_mar      = 1'b0;
        bus.ld_mdr      = 1'b0;
        bus.dr          = bus.ir[11:9];
        bus.sr1         = bus.ir[8:6];
        bus.sr2         = bus.ir[2:0];
        bus.aluk        = ALU_AND;
        bus.gate_alu    = 1'b0;
        bus.gate_pc     = 1'b0;
        bus.gate_marmux = 1'b0;
        bus.gate_mdr    = 1'b0;
        bus.a1m_sel     = A1M_SR1;
        bus.a2m_sel     = A2M_SEXT11;
        bus.pcmux_sel   = PCMUX_BUS;
        bus.marmux_sel  = MARMUX_ZEXT8;
        bus.mem_en      = 1'b0;
        bus.mem_rw      = 1'b0;

        case (state)
            S_IDLE: if (run) state_next = S_F1;
            S_F1: begin
                bus.gate_pc   = 1'b1;
                bus.ld_mar    = 1'b1;
                bus.pcmux_sel = PCMUX_INC;
                bus.ld_pc     = 1'b1;
                state_next    = S_F2;
            end
            S_F2, S_RD: begin
                bus.mem_en = 1'b1;
                timer_en   = 1'b1;
                // MDR captures memory only once the access has completed.
                if (timer_done) begin
                    bus.ld_mdr = 1'b1;
                    state_next = (state == S_F2) ? S_F3 : S_WB;
                end
            end
            S_F3: begin
                bus.gate_mdr = 1'b1;
                bus.ld_ir    = 1'b1;
                state_next   = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT:         state_next = S_ALU;
                    OP_BR:                          state_next = S_BR;
                    OP_JMP:                         state_next = S_JMP;
                    OP_LEA:                         state_next = S_LEA;
                    OP_LD, OP_LDR, OP_ST, OP_STR:   state_next = S_ADDR;
                    OP_TRAP: state_next = (bus.ir[7:0] == TRAP_HALT) ? S_HALT : S_ILL;
                    default:                        state_next = S_ILL;
                endcase
            end
            S_ALU: begin
                bus.gate_alu = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
                case (opcode)
                    OP_ADD:  bus.aluk = ALU_ADD;
                    OP_AND:  bus.aluk = ALU_AND;
                    default: bus.aluk = ALU_NOT;
                endcase
                state_next = end_state;
            end
            S_BR: begin
                if (br_taken) begin
                    bus.a1m_sel   = A1M_PC;
                    bus.a2m_sel   = A2M_SEXT9;
                    bus.pcmux_sel = PCMUX_ADDR;
                    bus.ld_pc     = 1'b1;
                end
                state_next = end_state;
            end
            S_JMP: begin
                bus.a1m_sel   = A1M_SR1;
                bus.a2m_sel   = A2M_ZERO;
                bus.pcmux_sel = PCMUX_ADDR;
                bus.ld_pc     = 1'b1;
                state_next    = end_state;
            end
            S_LEA: begin
                bus.a1m_sel     = A1M_PC;
                bus.a2m_sel     = A2M_SEXT9;
                bus.marmux_sel  = MARMUX_ADDR;
                bus.gate_marmux = 1'b1;
                bus.ld_reg      = 1'b1;
                state_next      = end_state;
            end
            S_ADDR: begin
                bus.marmux_sel  = MARMUX_ADDR;
                bus.gate_marmux = 1'b1;
                bus.ld_mar      = 1'b1;
                // PC-relative for LD/ST, base+offset6 for LDR/STR.
                if (opcode == OP_LD || opcode == OP_ST) begin
                    bus.a1m_sel = A1M_PC;
                    bus.a2m_sel = A2M_SEXT9;
                end else begin
                    bus.a1m_sel = A1M_SR1;
                    bus.a2m_sel = A2M_SEXT6;
                end
                state_next = is_load(opcode) ? S_RD : S_SD;
            end
            S_WB: begin
                bus.gate_mdr = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
                state_next   = end_state;
            end
            S_SD: begin
                // Store data register lives in the DR field; route it through the ALU.
                bus.sr1      = bus.ir[11:9];
                bus.aluk     = ALU_PASSA;
                bus.gate_alu = 1'b1;
                bus.ld_mdr   = 1'b1;
                state_next   = S_WR;
            end
            S_WR: begin
                bus.mem_rw = 1'b1;
                timer_en   = 1'b1;
                if (timer_done) state_next = end_state;
            end
            S_HALT, S_ILL: state_next = state;
            default:       state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3_control.sv
// Bench for lc3_control: two controllers (MEM_CYCLES=1 and 3) each drive a
// small behavioural LC3 datapath + memory. Expected architectural results are
// queued per program and compared once the program reaches HALT.
module tb_lc3_control;

    typedef struct packed {
        logic       ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr;
        logic [2:0] dr, sr1, sr2;
        logic [1:0] aluk;
        logic       gate_alu, gate_pc, gate_marmux, gate_mdr, a1m_sel;
        logic [1:0] a2m_sel, pcmux_sel;
        logic       marmux_sel, mem_en, mem_rw;
    } ctl_t;

    typedef enum int {O_REG, O_PC, O_CC, O_MEM, O_LAT, O_MDR, O_WR, O_LDPC, O_VIOL, O_HALT, O_ILL} obs_t;

    typedef struct {
        string       tag;
        int          k;
        obs_t        what;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, run0, run1;
    logic halted0, illegal0, halted1, illegal1;

    always #5 clk = ~clk;

    lc3_control_if bus0();
    lc3_control_if bus1();

    lc3_control #(.MEM_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .bus(bus0), .halted(halted0), .illegal(illegal0)
    );
    lc3_control #(.MEM_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .bus(bus1), .halted(halted1), .illegal(illegal1)
    );

    ctl_t c [2];
    assign c[0] = {bus0.ld_ir, bus0.ld_reg, bus0.ld_pc, bus0.ld_cc, bus0.ld_mar, bus0.ld_mdr,
                   bus0.dr, bus0.sr1, bus0.sr2, bus0.aluk,
                   bus0.gate_alu, bus0.gate_pc, bus0.gate_marmux, bus0.gate_mdr, bus0.a1m_sel,
                   bus0.a2m_sel, bus0.pcmux_sel, bus0.marmux_sel, bus0.mem_en, bus0.mem_rw};
    assign c[1] = {bus1.ld_ir, bus1.ld_reg, bus1.ld_pc, bus1.ld_cc, bus1.ld_mar, bus1.ld_mdr,
                   bus1.dr, bus1.sr1, bus1.sr2, bus1.aluk,
                   bus1.gate_alu, bus1.gate_pc, bus1.gate_marmux, bus1.gate_mdr, bus1.a1m_sel,
                   bus1.a2m_sel, bus1.pcmux_sel, bus1.marmux_sel, bus1.mem_en, bus1.mem_rw};

    // Behavioural datapath state, one copy per controller.
    logic [15:0] rf   [2][8];
    logic [15:0] mem  [2][256];
    logic [15:0] pc_r [2];
    logic [15:0] mar_r[2];
    logic [15:0] mdr_r[2];
    logic [15:0] ir_r [2];
    logic [2:0]  cc_r [2];

    assign bus0.ir = ir_r[0];
    assign bus0.cc = cc_r[0];
    assign bus1.ir = ir_r[1];
    assign bus1.cc = cc_r[1];

    // Preload port into the model: 1=mem 2=reg 3=pc 4=cc 5=clear.
    logic [2:0]  pl_op = 3'd0;
    int          pl_k = 0;
    logic [7:0]  pl_idx = 8'd0;
    logic [15:0] pl_data = 16'd0;

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        logic signed [15:0] t;
        t = v << (16 - bits);
        return t >>> (16 - bits);
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])       return 3'b100;
        else if (v == 0) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic logic [15:0] addr_out(input int k);
        logic [15:0] a1, a2;
        a1 = c[k].a1m_sel ? pc_r[k] : rf[k][c[k].sr1];
        case (c[k].a2m_sel)
            2'd0:    a2 = sext(ir_r[k], 11);
            2'd1:    a2 = sext(ir_r[k], 9);
            2'd2:    a2 = sext(ir_r[k], 6);
            default: a2 = 16'd0;
        endcase
        return a1 + a2;
    endfunction

    function automatic logic [15:0] alu_out(input int k);
        logic [15:0] a, b;
        a = rf[k][c[k].sr1];
        b = ir_r[k][5] ? sext(ir_r[k], 5) : rf[k][c[k].sr2];
        case (c[k].aluk)
            2'b00:   return a & b;
            2'b01:   return ~a;
            2'b10:   return a + b;
            default: return a;
        endcase
    endfunction

    function automatic logic [15:0] bus_val(input int k);
        if (c[k].gate_alu)    return alu_out(k);
        if (c[k].gate_pc)     return pc_r[k];
        if (c[k].gate_marmux) return c[k].marmux_sel ? addr_out(k) : {8'd0, ir_r[k][7:0]};
        if (c[k].gate_mdr)    return mdr_r[k];
        return 16'd0;
    endfunction

    function automatic logic [15:0] pc_next(input int k);
        case (c[k].pcmux_sel)
            2'd0:    return bus_val(k);
            2'd1:    return addr_out(k);
            default: return pc_r[k] + 16'd1;
        endcase
    endfunction

    function automatic logic [11:0] strobes(input int k);
        return {c[k].ld_ir, c[k].ld_reg, c[k].ld_pc, c[k].ld_cc, c[k].ld_mar, c[k].ld_mdr,
                c[k].gate_alu, c[k].gate_pc, c[k].gate_marmux, c[k].gate_mdr, c[k].mem_en, c[k].mem_rw};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (c[k].ld_ir)  ir_r[k] <= bus_val(k);
            if (c[k].ld_reg) rf[k][c[k].dr] <= bus_val(k);
            if (c[k].ld_pc)  pc_r[k] <= pc_next(k);
            if (c[k].ld_cc)  cc_r[k] <= cc_of(bus_val(k));
            if (c[k].ld_mar) mar_r[k] <= bus_val(k);
            if (c[k].ld_mdr) mdr_r[k] <= c[k].mem_en ? mem[k][mar_r[k][7:0]] : bus_val(k);
            if (c[k].mem_rw) mem[k][mar_r[k][7:0]] <= mdr_r[k];
        end
        case (pl_op)
            3'd1: mem[pl_k][pl_idx] <= pl_data;
            3'd2: rf[pl_k][pl_idx[2:0]] <= pl_data;
            3'd3: pc_r[pl_k] <= pl_data;
            3'd4: cc_r[pl_k] <= pl_data[2:0];
            3'd5: begin
                for (int i = 0; i < 256; i++) mem[pl_k][i] <= 16'd0;
                for (int r = 0; r < 8; r++) rf[pl_k][r] <= 16'd0;
                ir_r[pl_k]  <= 16'd0;
                mar_r[pl_k] <= 16'd0;
                mdr_r[pl_k] <= 16'd0;
            end
            default: ;
        endcase
    end

    // Strobe monitor, sampled on the falling edge.
    int          cyc = 0;
    int          f1_cnt[2]   = '{0, 0};
    int          f1_last[2]  = '{0, 0};
    int          f1_prev[2]  = '{0, 0};
    int          n_mdr[2]    = '{0, 0};
    int          n_wr[2]     = '{0, 0};
    int          n_ldpc[2]   = '{0, 0};
    int          n_strobe[2] = '{0, 0};
    int          viol[2]     = '{0, 0};
    logic [15:0] f1_pc[2]    = '{16'd0, 16'd0};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (c[k].gate_pc && c[k].ld_mar) begin
                f1_cnt[k]  <= f1_cnt[k] + 1;
                f1_prev[k] <= f1_last[k];
                f1_last[k] <= cyc;
                f1_pc[k]   <= pc_r[k];
            end
            if (c[k].ld_mdr) n_mdr[k] <= n_mdr[k] + 1;
            if (c[k].mem_rw) n_wr[k] <= n_wr[k] + 1;
            if (c[k].ld_pc)  n_ldpc[k] <= n_ldpc[k] + 1;
            if (strobes(k) != 12'd0) n_strobe[k] <= n_strobe[k] + 1;
            if ($countones({c[k].gate_alu, c[k].gate_pc, c[k].gate_marmux, c[k].gate_mdr}) > 1 ||
                (c[k].mem_rw && c[k].ld_mdr))
                viol[k] <= viol[k] + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    int s_mdr, s_wr, s_ldpc, s_viol;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int k, input obs_t what, input int idx,
                              input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.k = k; e.what = what; e.idx = idx; e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input exp_t e);
        case (e.what)
            O_REG:  return 32'(rf[e.k][e.idx]);
            O_PC:   return 32'(f1_pc[e.k]);
            O_CC:   return 32'(cc_r[e.k]);
            O_MEM:  return 32'(mem[e.k][e.idx]);
            O_LAT:  return f1_last[e.k] - f1_prev[e.k];
            O_MDR:  return n_mdr[e.k] - s_mdr;
            O_WR:   return n_wr[e.k] - s_wr;
            O_LDPC: return n_ldpc[e.k] - s_ldpc;
            O_VIOL: return viol[e.k] - s_viol;
            O_HALT: return 32'((e.k == 0) ? halted0 : halted1);
            default: return 32'((e.k == 0) ? illegal0 : illegal1);
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e), e.exp);
        end
    endtask

    task automatic poke(input logic [2:0] op, input int k, input logic [7:0] idx, input logic [15:0] data);
        pl_op = op; pl_k = k; pl_idx = idx; pl_data = data;
        @(posedge clk);
        #1 pl_op = 3'd0;
    endtask

    task automatic begin_test(input int k);
        rst_n = 1'b0;
        run0 = 1'b0;
        run1 = 1'b0;
        poke(3'd5, k, 8'd0, 16'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int k, input int budget);
        int n;
        s_mdr = n_mdr[k]; s_wr = n_wr[k]; s_ldpc = n_ldpc[k]; s_viol = viol[k];
        if (k == 0) run0 = 1'b1; else run1 = 1'b1;
        n = 0;
        while (!((k == 0) ? halted0 : halted1) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq($sformatf("halt_reached_k%0d", k), 32'((k == 0) ? halted0 : halted1), 32'd1);
        run0 = 1'b0;
        run1 = 1'b0;
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n;
        rst_n = 1'b0;
        run0 = 1'b0;
        run1 = 1'b0;

        // ADD R1,R1,#1 with R1=4, then HALT; reset state checked while idle.
        begin_test(0);
        poke(3'd1, 0, 8'h00, 16'h1261);
        poke(3'd1, 0, 8'h01, 16'hF025);
        poke(3'd2, 0, 8'd1, 16'd4);
        poke(3'd3, 0, 8'd0, 16'h0000);
        poke(3'd4, 0, 8'd0, 16'h0000);
        release_reset();
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_strobes", 32'(strobes(0)), 32'd0);
        check_eq("rst_halted", 32'(halted0), 32'd0);
        check_eq("rst_illegal", 32'(illegal0), 32'd0);
        check_eq("rst_idle_no_fetch", f1_cnt[0], 32'd0);
        expect_val("add_r1", 0, O_REG, 1, 32'd5);
        expect_val("add_cc", 0, O_CC, 0, 32'b001);
        expect_val("add_pc", 0, O_PC, 0, 32'd1);
        expect_val("add_lat", 0, O_LAT, 0, 32'd5);
        expect_val("add_onegate", 0, O_VIOL, 0, 32'd0);
        run_to_halt(0, 60);

        // BRz #+3 at x10, taken and not taken; BR nzp=000 never taken.
        for (int t = 0; t < 3; t++) begin
            begin_test(0);
            poke(3'd1, 0, 8'h10, (t == 2) ? 16'h0003 : 16'h0403);
            poke(3'd1, 0, 8'h11, 16'hF025);
            poke(3'd1, 0, 8'h14, 16'hF025);
            poke(3'd3, 0, 8'd0, 16'h0010);
            poke(3'd4, 0, 8'd0, (t == 0) ? 16'b010 : (t == 1) ? 16'b001 : 16'b111);
            release_reset();
            expect_val($sformatf("br%0d_pc", t), 0, O_PC, 0, (t == 0) ? 32'h14 : 32'h11);
            expect_val($sformatf("br%0d_ldpc", t), 0, O_LDPC, 0, (t == 0) ? 32'd3 : 32'd2);
            expect_val($sformatf("br%0d_lat", t), 0, O_LAT, 0, 32'd5);
            run_to_halt(0, 60);
        end

        // AND, NOT, LEA (CC kept), JMP R7 -> HALT at x30.
        begin_test(0);
        poke(3'd1, 0, 8'h00, 16'h5C42);
        poke(3'd1, 0, 8'h01, 16'h9A7F);
        poke(3'd1, 0, 8'h02, 16'hE1FE);
        poke(3'd1, 0, 8'h03, 16'hC1C0);
        poke(3'd1, 0, 8'h30, 16'hF025);
        poke(3'd2, 0, 8'd1, 16'h00F0);
        poke(3'd2, 0, 8'd2, 16'h0F3C);
        poke(3'd2, 0, 8'd7, 16'h0030);
        poke(3'd3, 0, 8'd0, 16'h0000);
        poke(3'd4, 0, 8'd0, 16'b010);
        release_reset();
        expect_val("and_r6", 0, O_REG, 6, 32'h0030);
        expect_val("not_r5", 0, O_REG, 5, 32'hFF0F);
        expect_val("lea_r0", 0, O_REG, 0, 32'h0001);
        expect_val("lea_cc_kept", 0, O_CC, 0, 32'b100);
        expect_val("jmp_pc", 0, O_PC, 0, 32'h30);
        expect_val("jmp_lat", 0, O_LAT, 0, 32'd5);
        expect_val("mix_ldpc", 0, O_LDPC, 0, 32'd6);
        run_to_halt(0, 100);

        // MEM_CYCLES=3: LD R2,#2 at x20 with M[x23]=x8000.
        begin_test(1);
        poke(3'd1, 1, 8'h20, 16'h2402);
        poke(3'd1, 1, 8'h21, 16'hF025);
        poke(3'd1, 1, 8'h23, 16'h8000);
        poke(3'd3, 1, 8'd0, 16'h0020);
        poke(3'd4, 1, 8'd0, 16'b010);
        release_reset();
        expect_val("ld_r2", 1, O_REG, 2, 32'h8000);
        expect_val("ld_cc", 1, O_CC, 0, 32'b100);
        expect_val("ld_lat", 1, O_LAT, 0, 32'd11);
        expect_val("ld_mdr_pulses", 1, O_MDR, 0, 32'd3);
        expect_val("ld_pc", 1, O_PC, 0, 32'h21);
        run_to_halt(1, 100);

        // MEM_CYCLES=3: STR R3,R4,#-1 with R4=x40, R3=xBEEF.
        begin_test(1);
        poke(3'd1, 1, 8'h00, 16'h773F);
        poke(3'd1, 1, 8'h01, 16'hF025);
        poke(3'd2, 1, 8'd3, 16'hBEEF);
        poke(3'd2, 1, 8'd4, 16'h0040);
        poke(3'd3, 1, 8'd0, 16'h0000);
        poke(3'd4, 1, 8'd0, 16'b010);
        release_reset();
        expect_val("str_mem", 1, O_MEM, 8'h3F, 32'hBEEF);
        expect_val("str_cc_kept", 1, O_CC, 0, 32'b010);
        expect_val("str_wr_cycles", 1, O_WR, 0, 32'd3);
        expect_val("str_lat", 1, O_LAT, 0, 32'd11);
        expect_val("str_mdr_pulses", 1, O_MDR, 0, 32'd3);
        expect_val("str_invariants", 1, O_VIOL, 0, 32'd0);
        run_to_halt(1, 100);

        // MEM_CYCLES=1: ST R3,#4 -> M[5].
        begin_test(0);
        poke(3'd1, 0, 8'h00, 16'h3604);
        poke(3'd1, 0, 8'h01, 16'hF025);
        poke(3'd2, 0, 8'd3, 16'h1234);
        poke(3'd3, 0, 8'd0, 16'h0000);
        release_reset();
        expect_val("st_mem", 0, O_MEM, 5, 32'h1234);
        expect_val("st_wr_cycles", 0, O_WR, 0, 32'd1);
        expect_val("st_lat", 0, O_LAT, 0, 32'd7);
        run_to_halt(0, 60);

        // TRAP x25, opcode 1101, TRAP with another vector.
        for (int t = 0; t < 3; t++) begin
            begin_test(0);
            poke(3'd1, 0, 8'h00, (t == 0) ? 16'hF025 : (t == 1) ? 16'hD000 : 16'hF021);
            poke(3'd3, 0, 8'd0, 16'h0000);
            release_reset();
            expect_val($sformatf("term%0d_halted", t), 0, O_HALT, 0, 32'd1);
            expect_val($sformatf("term%0d_illegal", t), 0, O_ILL, 0, (t == 0) ? 32'd0 : 32'd1);
            run_to_halt(0, 60);
            s = n_strobe[0];
            repeat (5) @(posedge clk);
            #2;
            check_eq($sformatf("term%0d_quiet", t), n_strobe[0] - s, 32'd0);
            check_eq($sformatf("term%0d_still_halted", t), 32'(halted0), 32'd1);
        end

        // Reset during the write of an ST (MEM_CYCLES=3).
        begin_test(1);
        poke(3'd1, 1, 8'h00, 16'h3604);
        poke(3'd1, 1, 8'h05, 16'h1111);
        poke(3'd2, 1, 8'd3, 16'hBEEF);
        poke(3'd3, 1, 8'd0, 16'h0000);
        release_reset();
        run1 = 1'b1;
        n = 0;
        while (!bus1.mem_rw && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("wr_reached", 32'(bus1.mem_rw), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async_strobes", 32'(strobes(1)), 32'd0);
        check_eq("rst_async_halted", 32'(halted1), 32'd0);
        run1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_no_partial_write", 32'(mem[1][5]), 32'h1111);
        release_reset();
        s = f1_cnt[1];
        repeat (5) @(posedge clk);
        #2;
        check_eq("rst_waits_for_run", f1_cnt[1] - s, 32'd0);
        check_eq("rst_idle_strobes", 32'(strobes(1)), 32'd0);
        run1 = 1'b1;
        n = 0;
        while (f1_cnt[1] == s && n < 5) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("rst_restart_fetch", 32'(f1_cnt[1] > s), 32'd1);
        run1 = 1'b0;

        check_eq("invariants_total", viol[0] + viol[1], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_control.md
Name: lc3_control

Overview:
- Microsequencer FSM that drives every control input of the LC3 datapath: register loads, bus gates, mux selects, ALU op and memory strobes.
- Consumes the datapath's IR (16 b) and CC (nzp, 3 b) outputs.
- Implements an integer subset: ADD, AND, NOT, BR, JMP, LD, LDR, ST, STR, LEA, TRAP x25 (HALT).
- Memory is modelled as fixed-latency, with MEM_CYCLES wait cycles per access.

Parameters:
- MEM_CYCLES, 1, cycles a memory read or write is held before completion (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue enable, sampled in IDLE and at end of every instruction.
- ir  in  16  datapath IR output.
- cc  in  3  datapath CC output {n,z,p}.
- ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr  out  1 each  register load enables.
- dr, sr1, sr2  out  3 each  regfile select.
- aluk  out  2  ALU op.
- gate_alu, gate_pc, gate_marmux, gate_mdr  out  1 each  bus drivers.
- a1m_sel  out  1  0=SR1, 1=PC.
- a2m_sel  out  2  0=sext11, 1=sext9, 2=sext6, 3=zero.
- pcmux_sel  out  2  0=bus, 1=addr adder, 2=PC+1.
- marmux_sel  out  1  0=zext8, 1=addr adder.
- mem_en  out  1  MDR source, 1=memory.
- mem_rw  out  1  1=memory write.
- halted  out  1  sticky, set by HALT or an illegal opcode.
- illegal  out  1  sticky, set by an unsupported opcode.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Output style: Moore-style outputs decoded combinationally from state and ir.
  - dr=ir[11:9], sr1=ir[8:6], sr2=ir[2:0] unless noted.
  - Every control not listed for a state is 0.
- Reset: state=IDLE, mem counter=0, halted=0, illegal=0, all load/gate/mem strobes 0.
  - Reset asserted mid-instruction aborts immediately. Strobes drop asynchronously with state; no partial write is completed.
- IDLE: no strobes. run=1 -> F1.
- F1: gate_pc, ld_mar, pcmux_sel=2, ld_pc -> F2.
- F2 (read wait): mem_en=1. Counter counts 0..MEM_CYCLES-1; ld_mdr only on the final count -> F3.
- F3: gate_mdr, ld_ir -> DEC.
- DEC: no strobes. Branch on ir[15:12]:
  - 0001, 0101, 1001 -> ALU
  - 0000 -> BR
  - 1100 -> JMP
  - 1110 -> LEA
  - 0010, 0110, 0011, 0111 -> ADDR
  - 1111 with ir[7:0]=x25 -> HALT
  - any other -> ILL
- ALU: gate_alu, ld_reg, ld_cc, aluk = ADD/AND/NOT per opcode.
- BR: taken iff |(ir[11:9] & cc). If taken: a1m_sel=1, a2m_sel=1, pcmux_sel=1, ld_pc. BR with nzp=000 never branches.
- JMP: a1m_sel=0, a2m_sel=3, pcmux_sel=1, ld_pc.
- LEA: a1m_sel=1, a2m_sel=1, marmux_sel=1, gate_marmux, ld_reg. CC is not updated.
- ADDR: marmux_sel=1, gate_marmux, ld_mar.
  - LD/ST: a1m_sel=1, a2m_sel=1.
  - LDR/STR: a1m_sel=0, a2m_sel=2.
  - Loads -> RD; stores -> SD.
- RD: same wait rule as F2 -> WB.
- WB: gate_mdr, ld_reg, ld_cc.
- SD: sr1=ir[11:9], aluk=PASSA, gate_alu, ld_mdr, mem_en=0 -> WR.
- WR: mem_rw=1 for exactly MEM_CYCLES cycles.
- End of instruction (ALU, BR, JMP, LEA, WB, last WR cycle): next state is F1 if run=1, else IDLE.
- HALT: set halted; the state is terminal until reset.
- ILL: set halted and illegal; terminal until reset.
- Invariants:
  - At most one gate_* asserted in any cycle.
  - mem_rw and ld_mdr are never asserted together.
  - The counter always returns to 0 on leaving F2, RD or WR.
- Latency with MEM_CYCLES=1: ALU/BR/JMP/LEA take 5 cycles from F1; LD/LDR/ST/STR take 7. Each access adds MEM_CYCLES-1 cycles.

Decomposition:
- lc3_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALU encodings ALU_AND=2'b00, ALU_NOT=2'b01, ALU_ADD=2'b10, ALU_PASSA=2'b11;
  - mux select constants for a1m, a2m, pcmux and marmux;
  - TRAP_HALT=8'h25.
- Sub-module lc3_mem_timer: load/count/done counter shared by F2, RD and WR.

Test Plan:
- Reset, then run=1 with M[0]=x1261 (ADD R1,R1,#1) and R1=4 -> 5 cycles; R1=5, CC=p, PC=1; every cycle has at most one gate.
- BRz #+3 at PC=x10, CC=z -> PC=x14. Same instruction with CC=p -> PC=x11 and ld_pc only in F1.
- MEM_CYCLES=3, LD R2,#2 at x20 with M[x23]=x8000 -> R2=x8000, CC=n. ld_mdr pulses exactly once per access; the instruction takes 11 cycles.
- STR R3,R4,#-1 with R4=x40, R3=xBEEF -> M[x3F]=xBEEF. mem_rw high for exactly MEM_CYCLES cycles; CC unchanged.
- TRAP x25 -> halted=1, illegal=0, no further strobes. Opcode 1101 -> halted=1, illegal=1.
- Assert rst_n=0 during the WR of an ST -> outputs drop to 0 immediately; after release, state=IDLE and it waits for run.
